wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the data width of the register file write port.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port a_valid, input, 1, write request from the pipeline writeback stage.
REQ-005 SHALL have port a_addr, input, 5, destination register for requester A.
REQ-006 SHALL have port a_data, input, XLEN, write data for requester A.
REQ-007 SHALL have port a_ready, output, 1, requester A is accepted this cycle.
REQ-008 SHALL have ports b_valid/b_addr/b_data/b_ready, mirroring REQ-004..007, for the multi-cycle unit (load/mul).
REQ-009 SHALL have port rsv_valid, input, 1, issue stage reserves a destination register.
REQ-010 SHALL have port rsv_addr, input, 5, register being reserved.
REQ-011 SHALL have port busy, output, 32, scoreboard; bit i=1 means a write to xi is pending.
REQ-012 SHALL have ports rf_we (output, 1), rf_wa (output, 5) and rf_wd (output, XLEN), driving the register file write port.

Function
REQ-013 SHALL complete a handshake on requester X when X_valid and X_ready are both 1 in the same cycle.
REQ-014 SHALL assert at most one of a_ready and b_ready in any cycle.
REQ-015 SHALL derive a_ready/b_ready combinationally from a_valid, b_valid and the last_grant flop, and SHALL hold both at 0 while rst=1.
REQ-016 Only one requester valid: that requester SHALL be granted (its ready=1) in the same cycle.
REQ-017 Both requesters valid: SHALL grant the requester that did not win the last grant (round-robin).
REQ-018 SHALL update last_grant only on a completed handshake.
REQ-019 After a completed handshake, rf_we SHALL be 1 in the next cycle, with rf_wa/rf_wd equal to the granted addr/data (1-cycle registered latency).
REQ-020 With no handshake in a cycle, rf_we SHALL be 0 in the next cycle, and rf_wa/rf_wd SHALL hold their previous values.
REQ-021 A handshake with addr=0 SHALL complete, and SHALL leave rf_we=0 in the next cycle (x0 writes dropped).
REQ-022 rsv_valid with rsv_addr!=0 SHALL set busy[rsv_addr] in the next cycle.
REQ-023 rsv_valid with rsv_addr=0 SHALL be ignored; busy[0] SHALL always read 0.
REQ-024 A cycle with rf_we=1 SHALL clear busy[rf_wa] in the next cycle.
REQ-025 Set (REQ-022) and clear (REQ-024) of the same bit in one cycle: set SHALL win.
REQ-026 Set and clear on different bits in one cycle SHALL both take effect.
REQ-027 Reservation of an already-busy register SHALL leave it busy, with no count kept.
REQ-028 A sustained two-requester contention SHALL alternate grants A,B,A,B..., so neither requester waits more than 1 cycle.
REQ-029 Requesters SHALL hold valid/addr/data stable until their handshake; the block SHALL NOT buffer a non-granted request.

Reset
REQ-030 While rst=1 at a clock edge, the next state SHALL be: rf_we=0, rf_wa=0, rf_wd=0, busy=0, last_grant=B (so A wins first contention).
REQ-031 Reset mid-operation SHALL discard any in-flight write: rf_we=0 the cycle after reset, and no pending grant is remembered.
REQ-032 rsv_valid and handshakes presented during rst=1 SHALL have no effect.

Verification
REQ-033 Reset, then a_valid=1, a_addr=5, a_data=0xDEADBEEF for 1 cycle -> a_ready=1 same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; following cycle rf_we=0.
REQ-034 a_valid=b_valid=1 held for 4 cycles (A addr 1, B addr 2) -> grants A,B,A,B; rf_wa sequence 1,2,1,2 one cycle later; a_ready&b_ready never both 1.
REQ-035 rsv_valid=1, rsv_addr=7 -> busy=0x00000080 next cycle; then B writes x7 -> busy[7]=0 the cycle after rf_we=1.
REQ-036 rf_we=1 with rf_wa=3 while rsv_valid=1, rsv_addr=3 in the same cycle -> busy[3]=1 next cycle.
REQ-037 a_valid=1, a_addr=0 -> handshake completes; rf_we stays 0; rsv_addr=0 -> busy stays 0x00000000.
REQ-038 Set busy[4], then issue a grant, then assert rst in the following cycle -> rf_we=0, busy=0, and first contention afterwards grants A.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter -- register-file write-port arbiter with destination scoreboard.
//
// Two writeback requesters share the single register-file write port:
// requester A (pipeline writeback stage) and requester B (multi-cycle
// load/mul unit). Grants are combinational and round-robin under
// contention. The granted write reaches the register file one cycle
// later. A 32-bit busy scoreboard records destination registers that
// the issue stage has reserved. The bit for a register clears when the
// write to that register leaves the port.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   a_valid/a_addr/a_data     requester A write request
//   a_ready                   requester A granted this cycle
//   b_valid/b_addr/b_data     requester B write request
//   b_ready                   requester B granted this cycle
//   rsv_valid/rsv_addr        issue-stage reservation of a destination
//   busy[31:0]                pending-write scoreboard (busy[0] always 0)
//   rf_we/rf_wa/rf_wd         registered register-file write port
module wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [4:0]      a_addr,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_addr,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic            rsv_valid,
    input  logic [4:0]      rsv_addr,
    output logic [31:0]     busy,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e          last_grant_q, last_grant_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_wa_q, rf_wa_d;
    logic [XLEN-1:0] rf_wd_q, rf_wd_d;
    logic [31:0]     busy_q, busy_d;

    logic [4:0]      sel_addr;
    logic [XLEN-1:0] sel_data;

    // Grant decode. Ready is only raised for a valid requester, so a raised
    // ready always means a completed handshake.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            if (a_valid && b_valid) begin
                // Under contention, grant whoever did not win last time.
                if (last_grant_q == GRANT_B) a_ready = 1'b1;
                else                         b_ready = 1'b1;
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    // Next-state logic for the grant history, write port and scoreboard.
    always_comb begin
        sel_addr     = b_ready ? b_addr : a_addr;
        sel_data     = b_ready ? b_data : a_data;

        last_grant_d = last_grant_q;
        if (a_ready)      last_grant_d = GRANT_A;
        else if (b_ready) last_grant_d = GRANT_B;

        // Writes to x0 still handshake but never reach the register file.
        // rf_wa/rf_wd only load on a real write and hold otherwise.
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        if ((a_ready || b_ready) && sel_addr != 5'd0) begin
            rf_we_d = 1'b1;
            rf_wa_d = sel_addr;
            rf_wd_d = sel_data;
        end

        // The clear is applied before the set, so the set wins when both
        // target the same bit in the same cycle.
        busy_d = busy_q;
        if (rf_we_q)                        busy_d[rf_wa_q]  = 1'b0;
        if (rsv_valid && rsv_addr != 5'd0)  busy_d[rsv_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so that every
        // flop samples its pre-edge value, whatever the statement order.
        if (rst) begin
            last_grant_q <= GRANT_B;
            rf_we_q      <= 1'b0;
            rf_wa_q      <= '0;
            rf_wd_q      <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_wa_q      <= rf_wa_d;
            rf_wd_q      <= rf_wd_d;
            busy_q       <= busy_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wa = rf_wa_q;
    assign rf_wd = rf_wd_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter. Each cycle a reference model
// predicts the grant and the next register-file write and scoreboard
// state. The grant is checked mid-cycle. The predicted registered state
// goes into a queue and is popped and compared after the next rising edge.
module tb_wb_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            a_valid, b_valid, rsv_valid;
    logic [4:0]      a_addr, b_addr, rsv_addr;
    logic [XLEN-1:0] a_data, b_data;
    logic            a_ready, b_ready;
    logic [31:0]     busy;
    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;

    wb_arbiter #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .rsv_valid(rsv_valid),
        .rsv_addr (rsv_addr),
        .busy     (busy),
        .rf_we    (rf_we),
        .rf_wa    (rf_wa),
        .rf_wd    (rf_wd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            we;
        logic            known;   // rf_wa/rf_wd value is defined
        logic [4:0]      wa;
        logic [XLEN-1:0] wd;
        logic [31:0]     busy;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: values expected after the most recent edge.
    logic            m_last_b = 1'b1;
    logic            m_we     = 1'b0;
    logic            m_known  = 1'b0;
    logic [4:0]      m_wa     = '0;
    logic [XLEN-1:0] m_wd     = '0;
    logic [31:0]     m_busy   = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [XLEN-1:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [XLEN-1:0] bd,
                         input logic rv, input logic [4:0] ra);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        rsv_valid = rv; rsv_addr = ra;
    endtask

    // Runs one clock cycle with the inputs already driven (at posedge+1).
    task automatic step();
        logic            ga, gb;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
        exp_t            e, o;
        #4;
        if (rst) begin
            ga = 1'b0; gb = 1'b0;
        end else if (a_valid && b_valid) begin
            ga = m_last_b; gb = !m_last_b;
        end else begin
            ga = a_valid; gb = b_valid;
        end
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        check("ready_exclusive", a_ready & b_ready, 0);

        if (rst) begin
            e        = '0;
            e.known  = 1'b1;
            m_last_b = 1'b1;
        end else begin
            e.busy = m_busy;
            if (m_we) e.busy[m_wa] = 1'b0;
            if (rsv_valid && rsv_addr != 5'd0) e.busy[rsv_addr] = 1'b1;
            e.we = 1'b0; e.known = m_known; e.wa = m_wa; e.wd = m_wd;
            if (ga || gb) begin
                addr     = ga ? a_addr : b_addr;
                data     = ga ? a_data : b_data;
                m_last_b = gb;
                if (addr != 5'd0) begin
                    e.we = 1'b1; e.known = 1'b1; e.wa = addr; e.wd = data;
                end else begin
                    // The write port contents after a dropped x0 write are
                    // left open; compare again after the next real write.
                    e.known = 1'b0;
                end
            end
        end
        m_we = e.we; m_known = e.known; m_wa = e.wa; m_wd = e.wd; m_busy = e.busy;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        check("rf_we", rf_we, o.we);
        if (o.known) begin
            check("rf_wa", rf_wa, o.wa);
            check("rf_wd", rf_wd, o.wd);
        end
        check("busy", busy, o.busy);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        rst = 1'b1;
        // Stimulus during reset must have no effect.
        drive(1, 5'd9, 32'h1111_1111, 1, 5'd10, 32'h2222_2222, 1, 5'd11);
        @(posedge clk); #1;
        step();
        step();

        rst = 1'b0;
        idle();
        check("reset_rf_we", rf_we, 0);
        check("reset_busy", busy, 0);
        check("reset_rf_wa", rf_wa, 0);
        check("reset_rf_wd", rf_wd, 0);

        // Sustained contention right after reset: A,B,A,B.
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'd1, 32'hA000_0001, 1, 5'd2, 32'hB000_0002, 0, 0);
            step();
            check("contention_wa", rf_wa, (i % 2 == 0) ? 1 : 2);
        end
        idle();

        // Single write from A.
        drive(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        step();
        check("single_wd", rf_wd, 32'hDEAD_BEEF);
        idle();

        // Reserve x7, then B writes x7 and clears it.
        drive(0, 0, 0, 0, 0, 0, 1, 5'd7);
        step();
        check("rsv7_busy", busy, 32'h0000_0080);
        drive(0, 0, 0, 1, 5'd7, 32'h0000_0777, 0, 0);
        step();
        idle();
        check("clear7_busy", busy, 0);

        // Set and clear of the same bit in one cycle: set wins.
        drive(1, 5'd3, 32'h33, 0, 0, 0, 1, 5'd3);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 5'd3);
        step();
        check("set_wins_busy3", busy[3], 1);
        // Re-reserving a busy register leaves it busy.
        drive(0, 0, 0, 0, 0, 0, 1, 5'd3);
        step();
        // Set and clear on different bits together.
        drive(0, 0, 0, 1, 5'd3, 32'h333, 1, 5'd9);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 5'd12);
        step();
        check("diff_bits_busy", busy, 32'h0000_1200);

        // x0 writes and reservations are dropped.
        drive(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 1, 5'd0);
        step();
        idle();

        // Reset mid-operation.
        drive(0, 0, 0, 0, 0, 0, 1, 5'd4);
        step();
        drive(0, 0, 0, 1, 5'd6, 32'h0666, 0, 0);
        step();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1, 5'd8);
        step();
        rst = 1'b0;
        drive(1, 5'd14, 32'hE, 1, 5'd15, 32'hF, 0, 0);
        step();
        check("post_reset_first_a", rf_wa, 14);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            step();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
